// File: rtl/dco_pkg.sv
// Shared types and default widths for the DCO frequency-locked-loop controller.
package dco_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAR,
        TRACK
    } fll_state_t;

    localparam int unsigned DCO_CODE_W = 8;
    localparam int unsigned DCO_CNT_W  = 16;

endpackage : dco_pkg

// File: rtl/dco_edge_counter.sv
// DCO edge counter: synchronises the raw oscillator output, detects rising
// edges and counts them over back-to-back fixed-length windows.
module dco_edge_counter
    import dco_pkg::*;
#(
    parameter int unsigned CNT_W    = DCO_CNT_W,
    parameter int unsigned WIN_CYC  = 1024,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             abort_i,
    input  logic             dco_i,
    output logic [CNT_W-1:0] meas_cnt_o,
    output logic             meas_valid_o
);

    localparam int unsigned          TMR_W    = $clog2(WIN_CYC);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(WIN_CYC - 1);

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;
    logic                rise;
    logic [TMR_W-1:0]    tmr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    meas_q;
    logic                valid_q;

    // Synchroniser chain plus the delayed copy used for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], dco_i};
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    // Rising edge on the last synchroniser stage and saturating count update
    always_comb begin
        rise  = sync_q[SYNC_STG-1] & ~prev_q;
        cnt_d = cnt_q;
        if (rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Window timer: the last cycle's edge is folded into the published count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q   <= '0;
            cnt_q   <= '0;
            meas_q  <= '0;
            valid_q <= 1'b0;
        end else if (!run_i || abort_i) begin
            tmr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (tmr_q == TMR_LAST) begin
            tmr_q   <= '0;
            cnt_q   <= '0;
            meas_q  <= cnt_d;
            valid_q <= 1'b1;
        end else begin
            tmr_q   <= tmr_q + 1'b1;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
        end
    end

    assign meas_cnt_o   = meas_q;
    assign meas_valid_o = valid_q;

endmodule : dco_edge_counter

// File: rtl/dco_fll_ctrl.sv
// DCO frequency-locked-loop controller: SAR coarse acquisition of the DCO
// code followed by +/-1 tracking, lock detection and code-limit flagging.
module dco_fll_ctrl
    import dco_pkg::*;
#(
    parameter int unsigned CODE_W   = DCO_CODE_W,
    parameter int unsigned CNT_W    = DCO_CNT_W,
    parameter int unsigned WIN_CYC  = 1024,
    parameter int unsigned SYNC_STG = 2,
    parameter int unsigned DISCARD  = 1,
    parameter int unsigned LOCK_TOL = 2,
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned INV_POL  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              start,
    input  logic              dco_in,
    input  logic [CNT_W-1:0]  target,
    output logic [CODE_W-1:0] dco_code,
    output logic [CNT_W-1:0]  meas_cnt,
    output logic              meas_valid,
    output logic              busy,
    output logic              locked,
    output logic              sat
);

    localparam int unsigned        IDX_W    = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int unsigned        DISC_W   = $clog2(DISCARD + 2);
    localparam int unsigned        LOCK_W   = $clog2(LOCK_N + 1);
    localparam logic [CODE_W-1:0]  CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]   IDX_TOP  = IDX_W'(CODE_W - 1);

    fll_state_t         state_q;
    logic [CODE_W-1:0]  code_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [IDX_W-1:0]   bit_q;
    logic [DISC_W-1:0]  disc_q;
    logic [LOCK_W-1:0]  inband_q;
    logic               busy_q;
    logic               locked_q;
    logic               sat_q;

    logic [CNT_W-1:0]   cnt_w;
    logic               valid_w;

    logic [CNT_W:0]     hi_ext;
    logic [CNT_W-1:0]   band_hi;
    logic [CNT_W-1:0]   band_lo;
    logic               step_up;
    logic               step_dn;
    logic               too_fast;
    logic [CODE_W-1:0]  sar_code_d;

    dco_edge_counter #(
        .CNT_W    (CNT_W),
        .WIN_CYC  (WIN_CYC),
        .SYNC_STG (SYNC_STG)
    ) u_edge_counter (
        .clk          (clk),
        .rst          (reset),
        .run_i        (busy_q),
        .abort_i      (~ena),
        .dco_i        (dco_in),
        .meas_cnt_o   (cnt_w),
        .meas_valid_o (valid_w)
    );

    // Lock band (clamped, never wrapping), step direction and next SAR trial code
    always_comb begin
        hi_ext  = {1'b0, tgt_q} + (CNT_W+1)'(LOCK_TOL);
        band_hi = hi_ext[CNT_W] ? '1 : hi_ext[CNT_W-1:0];
        band_lo = (tgt_q >= CNT_W'(LOCK_TOL)) ? (tgt_q - CNT_W'(LOCK_TOL)) : '0;
        if (INV_POL != 0) begin
            step_up = cnt_w > band_hi;
            step_dn = cnt_w < band_lo;
        end else begin
            step_up = cnt_w < band_lo;
            step_dn = cnt_w > band_hi;
        end
        too_fast   = (cnt_w > tgt_q) ^ (INV_POL != 0);
        sar_code_d = code_q;
        if (too_fast) begin
            sar_code_d[bit_q] = 1'b0;
        end
        if (bit_q != '0) begin
            sar_code_d[bit_q - 1'b1] = 1'b1;
        end
    end

    // Control FSM: acquisition, tracking, lock and saturation flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            code_q   <= CODE_MID;
            tgt_q    <= '0;
            bit_q    <= '0;
            disc_q   <= '0;
            inband_q <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
        end else if (!ena) begin
            state_q  <= IDLE;
            disc_q   <= '0;
            inband_q <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SAR;
                        tgt_q    <= target;
                        bit_q    <= IDX_TOP;
                        code_q   <= CODE_MID;
                        disc_q   <= DISC_W'(DISCARD);
                        inband_q <= '0;
                        busy_q   <= 1'b1;
                        locked_q <= 1'b0;
                        sat_q    <= 1'b0;
                    end
                end
                SAR: begin
                    if (valid_w) begin
                        if (disc_q != '0) begin
                            disc_q <= disc_q - 1'b1;
                        end else begin
                            code_q <= sar_code_d;
                            disc_q <= (sar_code_d != code_q) ? DISC_W'(DISCARD) : '0;
                            if (bit_q == '0) begin
                                state_q  <= TRACK;
                                inband_q <= '0;
                            end else begin
                                bit_q <= bit_q - 1'b1;
                            end
                        end
                    end
                end
                TRACK: begin
                    if (valid_w) begin
                        if (disc_q != '0) begin
                            disc_q <= disc_q - 1'b1;
                        end else if (step_up || step_dn) begin
                            inband_q <= '0;
                            locked_q <= 1'b0;
                            if ((step_up && (code_q == '1)) || (step_dn && (code_q == '0))) begin
                                sat_q <= 1'b1;
                            end else begin
                                code_q <= step_up ? (code_q + 1'b1) : (code_q - 1'b1);
                                disc_q <= DISC_W'(DISCARD);
                                sat_q  <= 1'b0;
                            end
                        end else begin
                            sat_q <= 1'b0;
                            if (inband_q < LOCK_W'(LOCK_N)) begin
                                inband_q <= inband_q + 1'b1;
                            end
                            if (inband_q >= LOCK_W'(LOCK_N - 1)) begin
                                locked_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dco_code   = code_q;
    assign meas_cnt   = cnt_w;
    assign meas_valid = valid_w;
    assign busy       = busy_q;
    assign locked     = locked_q;
    assign sat        = sat_q;

endmodule : dco_fll_ctrl

// File: tb/tb_dco_fll_ctrl.sv
// Self-checking bench for dco_fll_ctrl with a behavioural DCO model whose
// edge count per window equals the applied code.
module tb_dco_fll_ctrl;

    localparam int WIN   = 1024;
    localparam int CODEW = 8;
    localparam int TOL   = 2;
    localparam int LOCKN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Main instance
    logic        ena = 1'b0, start = 1'b0, dco_in = 1'b0;
    logic [15:0] target = '0;
    logic [7:0]  dco_code;
    logic [15:0] meas_cnt;
    logic        meas_valid, busy, locked, sat;

    // Code-saturation instance (target fixed above any reachable count)
    logic        s_ena = 1'b0, s_start = 1'b0, s_dco_in = 1'b0;
    logic [15:0] s_target = 16'hFFFF;
    logic [7:0]  s_code;
    logic [15:0] s_meas;
    logic        s_valid, s_busy, s_locked, s_sat;

    // Narrow-counter instance driven with a fixed 300 edges per window
    logic        c_ena = 1'b0, c_start = 1'b0, c_dco_in = 1'b0;
    logic [7:0]  c_target = 8'd0;
    logic [7:0]  c_code;
    logic [7:0]  c_meas;
    logic        c_valid, c_busy, c_locked, c_sat;

    int n_chk = 0;
    int n_err = 0;

    int acc_m = 0, acc_s = 0, acc_c = 0;
    bit ovr_en  = 1'b0;
    int ovr_val = 0;
    int offs [7] = '{-5, -3, -1, 0, 1, 3, 5};

    dco_fll_ctrl #(.CODE_W(8), .CNT_W(16), .WIN_CYC(WIN)) u_dut (
        .clk(clk), .reset(reset), .ena(ena), .start(start), .dco_in(dco_in),
        .target(target), .dco_code(dco_code), .meas_cnt(meas_cnt),
        .meas_valid(meas_valid), .busy(busy), .locked(locked), .sat(sat)
    );

    dco_fll_ctrl #(.CODE_W(8), .CNT_W(16), .WIN_CYC(WIN)) u_sat (
        .clk(clk), .reset(reset), .ena(s_ena), .start(s_start), .dco_in(s_dco_in),
        .target(s_target), .dco_code(s_code), .meas_cnt(s_meas),
        .meas_valid(s_valid), .busy(s_busy), .locked(s_locked), .sat(s_sat)
    );

    dco_fll_ctrl #(.CODE_W(8), .CNT_W(8), .WIN_CYC(WIN)) u_cnt8 (
        .clk(clk), .reset(reset), .ena(c_ena), .start(c_start), .dco_in(c_dco_in),
        .target(c_target), .dco_code(c_code), .meas_cnt(c_meas),
        .meas_valid(c_valid), .busy(c_busy), .locked(c_locked), .sat(c_sat)
    );

    always #5 clk = ~clk;

    // DCO models: phase accumulator advancing by the code every clk, so a
    // window of WIN cycles at a steady code holds exactly 'code' rising edges
    always @(negedge clk) begin
        acc_m    = (acc_m + (ovr_en ? ovr_val : int'(dco_code))) % WIN;
        dco_in   = (acc_m >= WIN / 2);
        acc_s    = (acc_s + int'(s_code)) % WIN;
        s_dco_in = (acc_s >= WIN / 2);
        acc_c    = (acc_c + 300) % WIN;
        c_dco_in = (acc_c >= WIN / 2);
    end

    function automatic int dco_count(input int code);
        return code;
    endfunction

    // Binary search for the largest code whose count does not exceed the target
    function automatic int sar_ref(input int tgt);
        int code = 0;
        for (int i = CODEW - 1; i >= 0; i--) begin
            int trial = code | (1 << i);
            if (!(dco_count(trial) > tgt)) code = trial;
        end
        return code;
    endfunction

    // One tracking decision: step toward the band, holding at the code limits
    function automatic int track_ref(input int code, input int cnt, input int tgt);
        int hi = (tgt + TOL > 65535) ? 65535 : tgt + TOL;
        int lo = (tgt - TOL < 0) ? 0 : tgt - TOL;
        if (cnt > hi) return (code > 0) ? code - 1 : code;
        if (cnt < lo) return (code < 255) ? code + 1 : code;
        return code;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_main(input logic [15:0] t);
        target = t;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_valids(input int n, input int budget, output int seen);
        int w = 0;
        seen = 0;
        while (seen < n && w < budget) begin
            tick(1);
            w++;
            if (meas_valid) seen++;
        end
    endtask

    task automatic wait_locked(input int budget, output int waited);
        waited = 0;
        while (!locked && waited < budget) begin
            tick(1);
            waited++;
        end
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w, nv, cur, cnt, t, exp_c, c1;

        // Reset state
        tick(3);
        chk_eq("rst_code",   32'(dco_code), 32'h80);
        chk_eq("rst_meas",   32'(meas_cnt), 32'h0);
        chk_eq("rst_valid",  32'(meas_valid), 32'h0);
        chk_eq("rst_busy",   32'(busy), 32'h0);
        chk_eq("rst_locked", 32'(locked), 32'h0);
        chk_eq("rst_sat",    32'(sat), 32'h0);
        reset = 1'b0;
        ena   = 1'b1;
        tick(2);

        // Asynchronous reset in the middle of acquisition
        start_main(16'd100);
        tick(2500);
        c1 = (dco_count(128) > 100) ? 64 : 192;
        chk_eq("sar1_busy", 32'(busy), 32'h1);
        chk_eq("sar1_code", 32'(dco_code), 32'(c1));
        chk_eq("sar1_meas", 32'(meas_cnt), 32'(dco_count(128)));
        #2 reset = 1'b1;
        #1;
        chk_eq("arst_code",   32'(dco_code), 32'h80);
        chk_eq("arst_busy",   32'(busy), 32'h0);
        chk_eq("arst_locked", 32'(locked), 32'h0);
        chk_eq("arst_valid",  32'(meas_valid), 32'h0);
        chk_eq("arst_meas",   32'(meas_cnt), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Side instances run in the background and are checked later
        s_ena = 1'b1; c_ena = 1'b1;
        s_start = 1'b1; c_start = 1'b1;
        tick(1);
        s_start = 1'b0; c_start = 1'b0;

        // Full acquisition to target 100, then lock
        start_main(16'd100);
        tick(8 * 2 * WIN + 4);
        chk_eq("sar_code",   32'(dco_code), 32'(sar_ref(100)));
        chk_eq("sar_locked", 32'(locked), 32'h0);
        chk_eq("sar_busy",   32'(busy), 32'h1);
        wait_locked(8 * WIN, w);
        chk_eq("lock_set", 32'(locked), 32'h1);
        chk_eq("lock_lat", 32'((w >= LOCKN * WIN) && (w <= (LOCKN + 2) * WIN)), 32'h1);
        tick(WIN);
        chk_eq("stable_code",   32'(dco_code), 32'(sar_ref(100)));
        chk_eq("stable_locked", 32'(locked), 32'h1);
        chk_eq("stable_sat",    32'(sat), 32'h0);

        // Background instances: code limit and counter saturation
        chk_eq("satc_code",   32'(s_code), 32'hFF);
        chk_eq("satc_sat",    32'(s_sat), 32'h1);
        chk_eq("satc_locked", 32'(s_locked), 32'h0);
        chk_eq("satc_busy",   32'(s_busy), 32'h1);
        chk_eq("cnt8_meas",   32'(c_meas), 32'd255);

        // Band edge: upper edge holds lock, one past it steps slower
        ovr_val = 102;
        ovr_en  = 1'b1;
        wait_valids(2, 3 * WIN, nv);
        chk_eq("band_valids", 32'(nv), 32'd2);
        chk_eq("band_meas",   32'(meas_cnt), 32'd102);
        chk_eq("band_code",   32'(dco_code), 32'(track_ref(100, 102, 100)));
        chk_eq("band_locked", 32'(locked), 32'h1);
        ovr_val = 103;
        w = 0;
        while (dco_code == 8'd100 && w < 3 * WIN) begin
            tick(1);
            w++;
        end
        ovr_val = 100;
        chk_eq("over_code",   32'(dco_code), 32'(track_ref(100, 103, 100)));
        chk_eq("over_locked", 32'(locked), 32'h0);
        wait_valids(2, 3 * WIN, nv);

        // Random forced counts around the target: one tracking decision each
        cur = int'(dco_code);
        for (int it = 0; it < 3; it++) begin
            cnt     = 100 + offs[$urandom_range(0, 6)];
            exp_c   = track_ref(cur, cnt, 100);
            ovr_val = cnt;
            w = 0;
            nv = 0;
            while (int'(dco_code) == cur && nv < 3 && w < 4 * WIN) begin
                tick(1);
                w++;
                if (meas_valid) nv++;
            end
            ovr_val = 100;
            chk_eq("rnd_trk_code", 32'(dco_code), 32'(exp_c));
            if (exp_c != cur) chk_eq("rnd_trk_unlock", 32'(locked), 32'h0);
            cur = exp_c;
            wait_valids(2, 3 * WIN, nv);
        end
        ovr_en = 1'b0;

        // ena drop while tracking
        wait_locked(12 * WIN, w);
        chk_eq("pre_drop_locked", 32'(locked), 32'h1);
        cur = int'(dco_code);
        ena = 1'b0;
        tick(1);
        chk_eq("drop_busy",   32'(busy), 32'h0);
        chk_eq("drop_locked", 32'(locked), 32'h0);
        chk_eq("drop_sat",    32'(sat), 32'h0);
        chk_eq("drop_code",   32'(dco_code), 32'(cur));
        start_main(16'd55);
        tick(3);
        chk_eq("dis_start_busy", 32'(busy), 32'h0);
        nv = 0;
        for (int i = 0; i < WIN + 100; i++) begin
            tick(1);
            if (meas_valid) nv++;
        end
        chk_eq("idle_valids", 32'(nv), 32'd0);
        chk_eq("idle_code",   32'(dco_code), 32'(cur));

        // Restart with a random target; later target and start changes ignored
        ena = 1'b1;
        tick(1);
        t = $urandom_range(20, 235);
        start_main(16'(t));
        target = 16'(t) ^ 16'h0055;
        tick(8 * 2 * WIN + 4);
        chk_eq("rnd_sar_code", 32'(dco_code), 32'(sar_ref(t)));
        wait_locked(8 * WIN, w);
        chk_eq("rnd_locked", 32'(locked), 32'h1);
        chk_eq("rnd_code",   32'(dco_code), 32'(sar_ref(t)));
        start_main(16'd200);
        tick(2 * WIN);
        chk_eq("busy_start_code",   32'(dco_code), 32'(sar_ref(t)));
        chk_eq("busy_start_locked", 32'(locked), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_dco_fll_ctrl
